// File: rtl/lock_access_controller.sv
// Keypad door-lock controller: sequences digit entry, checks it against a
// programmable stored code, counts failures and times lockout / auto-relock.
module lock_access_controller #(
    parameter int                     CODE_LEN       = 6,
    parameter logic [4*CODE_LEN-1:0]  DEFAULT_CODE   = 24'h335256,
    parameter int                     MAX_FAIL       = 3,
    parameter int                     LOCKOUT_CYCLES = 1000,
    parameter int                     UNLOCK_CYCLES  = 500,
    parameter int                     ENTRY_TIMEOUT  = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_in,
    input  logic       lock_req,
    input  logic       prog_en,
    output logic       locked,
    output logic       lockout,
    output logic       unlock_pulse,
    output logic       fail_pulse,
    output logic [3:0] fail_cnt,
    output logic [2:0] state
);

    localparam int CODE_W = 4 * CODE_LEN;
    localparam int MAX_LU = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int MAX_T  = (MAX_LU > ENTRY_TIMEOUT) ? MAX_LU : ENTRY_TIMEOUT;
    localparam int TMR_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int CNT_W  = $clog2(CODE_LEN + 1);

    localparam logic [TMR_W-1:0] LOCK_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] UNLOCK_LOAD = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] ENTRY_LOAD  = TMR_W'(ENTRY_TIMEOUT - 1);
    localparam logic [3:0]       KEY_CLEAR   = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_UNLOCKED = 3'd2,
        S_LOCKOUT  = 3'd3,
        S_PROGRAM  = 3'd4
    } state_t;

    state_t             cur;
    logic [TMR_W-1:0]   tmr;
    logic [CNT_W-1:0]   digit_cnt;
    logic [CODE_W-1:0]  code_reg;
    logic [CODE_W-1:0]  shift_reg;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v >= 4'(MAX_FAIL))
            return 4'(MAX_FAIL);
        return v + 4'd1;
    endfunction

    function automatic logic [CODE_W-1:0] shift_in(input logic [CODE_W-1:0] r,
                                                   input logic [3:0]        d);
        return {r[CODE_W-5:0], d};
    endfunction

    logic               is_digit;
    logic               last_digit;
    logic               tmr_zero;
    logic [CODE_W-1:0]  shift_next;
    logic [3:0]         fail_next;

    assign is_digit   = (key_in != KEY_CLEAR);
    assign last_digit = (digit_cnt == CNT_W'(CODE_LEN - 1));
    assign tmr_zero   = (tmr == '0);
    assign shift_next = shift_in(shift_reg, key_in);
    assign fail_next  = sat_inc(fail_cnt);
    assign state      = cur;

    // Digit shifter shared by ENTRY and PROGRAM. Digits shifted in other states
    // are flushed out by the CODE_LEN digits of any sequence that completes.
    always_ff @(posedge clk) begin
        if (key_valid && is_digit)
            shift_reg <= shift_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur          <= S_IDLE;
            tmr          <= '0;
            digit_cnt    <= '0;
            fail_cnt     <= '0;
            code_reg     <= DEFAULT_CODE;
            locked       <= 1'b1;
            lockout      <= 1'b0;
            unlock_pulse <= 1'b0;
            fail_pulse   <= 1'b0;
        end else begin
            unlock_pulse <= 1'b0;
            fail_pulse   <= 1'b0;
            case (cur)
                S_IDLE: begin
                    locked  <= 1'b1;
                    lockout <= 1'b0;
                    if (key_valid && is_digit) begin
                        cur       <= S_ENTRY;
                        digit_cnt <= CNT_W'(1);
                        tmr       <= ENTRY_LOAD;
                    end
                end

                S_ENTRY: begin
                    if (key_valid) begin
                        if (!is_digit) begin
                            cur       <= S_IDLE;
                            digit_cnt <= '0;
                        end else if (last_digit) begin
                            digit_cnt <= '0;
                            if (shift_next == code_reg) begin
                                cur          <= S_UNLOCKED;
                                locked       <= 1'b0;
                                unlock_pulse <= 1'b1;
                                fail_cnt     <= '0;
                                tmr          <= UNLOCK_LOAD;
                            end else begin
                                fail_pulse <= 1'b1;
                                if (fail_next == 4'(MAX_FAIL)) begin
                                    cur      <= S_LOCKOUT;
                                    lockout  <= 1'b1;
                                    fail_cnt <= '0;
                                    tmr      <= LOCK_LOAD;
                                end else begin
                                    cur      <= S_IDLE;
                                    fail_cnt <= fail_next;
                                end
                            end
                        end else begin
                            digit_cnt <= digit_cnt + CNT_W'(1);
                            tmr       <= ENTRY_LOAD;
                        end
                    end else if (tmr_zero) begin
                        cur       <= S_IDLE;
                        digit_cnt <= '0;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end

                // Relock request outranks both timer expiry and a programming key
                S_UNLOCKED: begin
                    if (lock_req || tmr_zero) begin
                        cur    <= S_IDLE;
                        locked <= 1'b1;
                    end else if (key_valid && prog_en && is_digit) begin
                        cur       <= S_PROGRAM;
                        digit_cnt <= CNT_W'(1);
                        tmr       <= ENTRY_LOAD;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end

                S_PROGRAM: begin
                    if (lock_req) begin
                        cur       <= S_IDLE;
                        locked    <= 1'b1;
                        digit_cnt <= '0;
                    end else if (key_valid) begin
                        if (!is_digit) begin
                            cur       <= S_UNLOCKED;
                            digit_cnt <= '0;
                            tmr       <= UNLOCK_LOAD;
                        end else if (last_digit) begin
                            code_reg  <= shift_next;
                            cur       <= S_UNLOCKED;
                            digit_cnt <= '0;
                            tmr       <= UNLOCK_LOAD;
                        end else begin
                            digit_cnt <= digit_cnt + CNT_W'(1);
                            tmr       <= ENTRY_LOAD;
                        end
                    end else if (tmr_zero) begin
                        cur       <= S_IDLE;
                        locked    <= 1'b1;
                        digit_cnt <= '0;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end

                S_LOCKOUT: begin
                    if (tmr_zero) begin
                        cur     <= S_IDLE;
                        lockout <= 1'b0;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end

                default: begin
                    cur       <= S_IDLE;
                    locked    <= 1'b1;
                    lockout   <= 1'b0;
                    digit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_access_controller.sv
// Randomised bench for lock_access_controller: an event-level reference model
// predicts every cycle's outputs into a queue that a separate monitor drains.
module tb_lock_access_controller;

    localparam int CODE_LEN       = 6;
    localparam int MAX_FAIL       = 3;
    localparam int LOCKOUT_CYCLES = 20;
    localparam int UNLOCK_CYCLES  = 30;
    localparam int ENTRY_TIMEOUT  = 10;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_UNLOCKED = 2, M_LOCKOUT = 3, M_PROGRAM = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_in = 4'd0;
    logic       lock_req = 1'b0;
    logic       prog_en = 1'b0;
    logic       locked, lockout, unlock_pulse, fail_pulse;
    logic [3:0] fail_cnt;
    logic [2:0] state;

    lock_access_controller #(
        .CODE_LEN(CODE_LEN), .DEFAULT_CODE(24'h335256), .MAX_FAIL(MAX_FAIL),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .UNLOCK_CYCLES(UNLOCK_CYCLES),
        .ENTRY_TIMEOUT(ENTRY_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_in(key_in),
        .lock_req(lock_req), .prog_en(prog_en), .locked(locked), .lockout(lockout),
        .unlock_pulse(unlock_pulse), .fail_pulse(fail_pulse), .fail_cnt(fail_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lk;
        logic       lo;
        logic       up;
        logic       fp;
        logic [3:0] fc;
        logic [2:0] st;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: mode plus absolute-cycle deadlines and digit queues
    int  n_edge = 0;
    int  m_mode = M_IDLE;
    int  m_fails = 0;
    int  m_key_dl = 0, m_unl_dl = 0, m_lock_dl = 0;
    int  m_buf[$];
    int  m_code[CODE_LEN];
    bit  m_up, m_fp;

    function automatic bit buf_matches();
        for (int i = 0; i < CODE_LEN; i++)
            if (m_buf[i] != m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [23:0] model_code();
        logic [23:0] v = '0;
        for (int i = 0; i < CODE_LEN; i++)
            v = {v[19:0], 4'(m_code[i])};
        return v;
    endfunction

    task automatic model_edge(input bit rst, input bit kv, input int key,
                              input bit lr, input bit pe);
        n_edge++;
        m_up = 1'b0;
        m_fp = 1'b0;
        if (rst) begin
            m_mode  = M_IDLE;
            m_fails = 0;
            m_buf.delete();
            m_code  = '{3, 3, 5, 2, 5, 6};
        end else begin
            case (m_mode)
                M_IDLE: if (kv && key != 15) begin
                    m_buf.delete();
                    m_buf.push_back(key);
                    m_mode   = M_ENTRY;
                    m_key_dl = n_edge + ENTRY_TIMEOUT;
                end
                M_ENTRY: begin
                    if (kv) begin
                        if (key == 15) m_mode = M_IDLE;
                        else begin
                            m_buf.push_back(key);
                            if (m_buf.size() == CODE_LEN) begin
                                if (buf_matches()) begin
                                    m_mode = M_UNLOCKED; m_up = 1'b1; m_fails = 0;
                                    m_unl_dl = n_edge + UNLOCK_CYCLES;
                                end else begin
                                    m_fp = 1'b1;
                                    m_fails++;
                                    if (m_fails >= MAX_FAIL) begin
                                        m_mode = M_LOCKOUT; m_fails = 0;
                                        m_lock_dl = n_edge + LOCKOUT_CYCLES;
                                    end else m_mode = M_IDLE;
                                end
                            end else m_key_dl = n_edge + ENTRY_TIMEOUT;
                        end
                    end else if (n_edge == m_key_dl) m_mode = M_IDLE;
                end
                M_UNLOCKED: begin
                    if (lr || n_edge == m_unl_dl) m_mode = M_IDLE;
                    else if (kv && pe && key != 15) begin
                        m_buf.delete();
                        m_buf.push_back(key);
                        m_mode   = M_PROGRAM;
                        m_key_dl = n_edge + ENTRY_TIMEOUT;
                    end
                end
                M_PROGRAM: begin
                    if (lr) m_mode = M_IDLE;
                    else if (kv) begin
                        if (key == 15) begin
                            m_mode = M_UNLOCKED; m_unl_dl = n_edge + UNLOCK_CYCLES;
                        end else begin
                            m_buf.push_back(key);
                            if (m_buf.size() == CODE_LEN) begin
                                for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_buf[i];
                                m_mode = M_UNLOCKED; m_unl_dl = n_edge + UNLOCK_CYCLES;
                            end else m_key_dl = n_edge + ENTRY_TIMEOUT;
                        end
                    end else if (n_edge == m_key_dl) m_mode = M_IDLE;
                end
                M_LOCKOUT: if (n_edge == m_lock_dl) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic step(input bit rst, input bit kv, input logic [3:0] key,
                        input bit lr, input bit pe);
        obs_t e;
        @(negedge clk);
        #1;
        reset = rst; key_valid = kv; key_in = key; lock_req = lr; prog_en = pe;
        @(posedge clk);
        model_edge(rst, kv, int'(key), lr, pe);
        e.lk = !(m_mode == M_UNLOCKED || m_mode == M_PROGRAM);
        e.lo = (m_mode == M_LOCKOUT);
        e.up = m_up;
        e.fp = m_fp;
        e.fc = 4'(m_fails);
        e.st = 3'(m_mode);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [3:0] k, input bit pe);
        step(1'b0, 1'b1, k, 1'b0, pe);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [23:0] c, input bit pe);
        for (int i = 0; i < CODE_LEN; i++)
            press(c[23-4*i -: 4], pe);
    endtask

    task automatic relock();
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        idle(1);
    endtask

    function automatic logic [23:0] rand_code();
        logic [23:0] v = '0;
        for (int i = 0; i < CODE_LEN; i++)
            v = {v[19:0], 4'($urandom_range(0, 14))};
        return v;
    endfunction

    // Monitor: outputs are registered, so sampling on the falling edge is stable
    int   mon_n = 0;
    obs_t mon_e, mon_a;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {locked, lockout, unlock_pulse, fail_pulse, fail_cnt, state};
            mon_n++;
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL outputs@edge%0d: got lk=%b lo=%b up=%b fp=%b fc=%0d st=%0d, want lk=%b lo=%b up=%b fp=%b fc=%0d st=%0d",
                         mon_n, mon_a.lk, mon_a.lo, mon_a.up, mon_a.fp, mon_a.fc, mon_a.st,
                         mon_e.lk, mon_e.lo, mon_e.up, mon_e.fp, mon_e.fc, mon_e.st);
            end
        end
    end

    initial begin
        do_reset();
        idle(2);

        // Default code unlocks, then auto-relock
        enter_code(24'h335256, 1'b0);
        idle(UNLOCK_CYCLES + 4);

        // Three failures -> lockout; keys and lock_req ignored meanwhile
        repeat (MAX_FAIL) enter_code(24'h335257, 1'b0);
        press(4'd3, 1'b0);
        press(4'd3, 1'b0);
        relock();
        idle(LOCKOUT_CYCLES);

        // Manual relock and relock-vs-key priority
        enter_code(24'h335256, 1'b0);
        idle(4);
        relock();
        enter_code(24'h335256, 1'b0);
        step(1'b0, 1'b1, 4'd1, 1'b1, 1'b1);
        idle(2);

        // Reprogram to 123456
        enter_code(24'h335256, 1'b0);
        enter_code(24'h123456, 1'b1);
        relock();
        enter_code(24'h335256, 1'b0);
        enter_code(24'h123456, 1'b0);

        // Aborted programming keeps the code
        press(4'd1, 1'b1); press(4'd2, 1'b1); press(4'd3, 1'b1); press(4'hF, 1'b1);
        relock();
        enter_code(24'h123456, 1'b0);
        relock();

        // Entry timeout and CLEAR with a nonzero failure count
        enter_code(24'h111111, 1'b0);
        press(4'd3, 1'b0); press(4'd3, 1'b0); press(4'd5, 1'b0);
        idle(ENTRY_TIMEOUT + 2);
        press(4'd3, 1'b0); press(4'd3, 1'b0); press(4'hF, 1'b0);
        idle(2);

        // Reset mid-entry, mid-lockout and after reprogramming
        press(4'd1, 1'b0); press(4'd2, 1'b0);
        do_reset();
        enter_code(24'h335256, 1'b0);
        relock();
        repeat (MAX_FAIL) enter_code(24'h000000, 1'b0);
        idle(5);
        do_reset();
        enter_code(24'h335256, 1'b0);
        enter_code(24'h987654, 1'b1);
        do_reset();
        enter_code(24'h335256, 1'b0);
        relock();

        // Randomised traffic
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1: enter_code(model_code(), 1'($urandom_range(0, 1)));
                2:    enter_code(rand_code(), 1'b0);
                3: begin
                    repeat ($urandom_range(1, 4)) press(4'($urandom_range(0, 14)), 1'b0);
                    if ($urandom_range(0, 1) == 1) press(4'hF, 1'b0);
                    else idle(ENTRY_TIMEOUT + $urandom_range(0, 3));
                end
                4: idle($urandom_range(1, 40));
                5: relock();
                6: enter_code(rand_code(), 1'b1);
                7: step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                8: repeat (10)
                       step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
                default: if ($urandom_range(0, 7) == 0) do_reset();
                         else idle(1);
            endcase
        end

        idle(2);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
